// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types, win-line masks and board helpers for the tic-tac-toe controller
package ttt_pkg;

  typedef logic [8:0] board_t;

  localparam int N_LINES = 8;

  localparam board_t WIN_LINES [N_LINES] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P_WAIT,
    ST_C_EVAL,
    ST_O_CHECK,
    ST_DONE
  } state_t;

  function automatic logic is_onehot(input board_t v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

  function automatic logic has_line(input board_t b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
      if ((b & WIN_LINES[i]) == WIN_LINES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ttt_line_detect.sv
// rtl/ttt_line_detect.sv - combinational check that one side's cells cover any win line
module ttt_line_detect
  import ttt_pkg::*;
(
  input  board_t i_board,
  output logic   o_won
);

  assign o_won = has_line(i_board);

endmodule

// File: rtl/ttt_board_ctrl.sv
// rtl/ttt_board_ctrl.sv - registered board, turn sequencing, move commit and result detection
module ttt_board_ctrl
  import ttt_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       comp_first,
  input  logic       player_valid,
  input  logic [8:0] player_move,
  input  logic [8:0] comp_move,
  output logic [8:0] xs,
  output logic [8:0] os,
  output logic       player_turn,
  output logic       win_x,
  output logic       win_o,
  output logic       draw,
  output logic       illegal,
  output logic       comp_fault,
  output logic [3:0] move_count
);

  state_t     r_state, w_state;
  board_t     r_xs, w_xs;
  board_t     r_os, w_os;
  logic [3:0] r_cnt, w_cnt;
  logic       r_wx, w_wx;
  logic       r_wo, w_wo;
  logic       r_dr, w_dr;
  logic       r_ill, w_ill;
  logic       r_ft, w_ft;
  logic       r_pt, w_pt;

  board_t     w_occ;
  logic       w_x_won;
  logic       w_o_won;

  assign w_occ = r_xs | r_os;

  ttt_line_detect u_det_x (.i_board(r_xs), .o_won(w_x_won));
  ttt_line_detect u_det_o (.i_board(r_os), .o_won(w_o_won));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_xs    <= '0;
      r_os    <= '0;
      r_cnt   <= '0;
      r_wx    <= 1'b0;
      r_wo    <= 1'b0;
      r_dr    <= 1'b0;
      r_ill   <= 1'b0;
      r_ft    <= 1'b0;
      r_pt    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_xs    <= w_xs;
      r_os    <= w_os;
      r_cnt   <= w_cnt;
      r_wx    <= w_wx;
      r_wo    <= w_wo;
      r_dr    <= w_dr;
      r_ill   <= w_ill;
      r_ft    <= w_ft;
      r_pt    <= w_pt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_xs    = r_xs;
    w_os    = r_os;
    w_cnt   = r_cnt;
    w_wx    = r_wx;
    w_wo    = r_wo;
    w_dr    = r_dr;
    w_ft    = r_ft;
    w_ill   = 1'b0;

    if (new_game) begin
      w_xs    = '0;
      w_os    = '0;
      w_cnt   = '0;
      w_wx    = 1'b0;
      w_wo    = 1'b0;
      w_dr    = 1'b0;
      w_ft    = 1'b0;
      w_state = comp_first ? ST_C_EVAL : ST_P_WAIT;
    end else begin
      case (r_state)
        ST_P_WAIT: begin
          if (player_valid) begin
            if (is_onehot(player_move) && ((player_move & w_occ) == '0)) begin
              w_xs    = r_xs | player_move;
              w_cnt   = r_cnt + 4'd1;
              w_state = ST_C_EVAL;
            end else begin
              w_ill = 1'b1;
            end
          end
        end
        // X win and full board take precedence over whatever the selector offers
        ST_C_EVAL: begin
          if (w_x_won) begin
            w_wx    = 1'b1;
            w_state = ST_DONE;
          end else if (r_cnt == 4'd9) begin
            w_dr    = 1'b1;
            w_state = ST_DONE;
          end else if (is_onehot(comp_move) && ((comp_move & w_occ) == '0)) begin
            w_os    = r_os | comp_move;
            w_cnt   = r_cnt + 4'd1;
            w_state = ST_O_CHECK;
          end else begin
            w_ft    = 1'b1;
            w_state = ST_DONE;
          end
        end
        ST_O_CHECK: begin
          if (w_o_won) begin
            w_wo    = 1'b1;
            w_state = ST_DONE;
          end else if (r_cnt == 4'd9) begin
            w_dr    = 1'b1;
            w_state = ST_DONE;
          end else begin
            w_state = ST_P_WAIT;
          end
        end
        default: begin
        end
      endcase
    end

    w_pt = (w_state == ST_P_WAIT);
  end

  assign xs          = r_xs;
  assign os          = r_os;
  assign move_count  = r_cnt;
  assign win_x       = r_wx;
  assign win_o       = r_wo;
  assign draw        = r_dr;
  assign illegal     = r_ill;
  assign comp_fault  = r_ft;
  assign player_turn = r_pt;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb/tb_ttt_board_ctrl.sv - table-driven scoreboard bench for ttt_board_ctrl
module tb_ttt_board_ctrl;

  logic       clock;
  logic       reset_n;
  logic       new_game;
  logic       comp_first;
  logic       player_valid;
  logic [8:0] player_move;
  logic [8:0] comp_move;
  logic [8:0] xs;
  logic [8:0] os;
  logic       player_turn;
  logic       win_x;
  logic       win_o;
  logic       draw;
  logic       illegal;
  logic       comp_fault;
  logic [3:0] move_count;

  ttt_board_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .new_game    (new_game),
    .comp_first  (comp_first),
    .player_valid(player_valid),
    .player_move (player_move),
    .comp_move   (comp_move),
    .xs          (xs),
    .os          (os),
    .player_turn (player_turn),
    .win_x       (win_x),
    .win_o       (win_o),
    .draw        (draw),
    .illegal     (illegal),
    .comp_fault  (comp_fault),
    .move_count  (move_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       ng;
    logic       cf;
    logic       pv;
    logic [8:0] pm;
    logic [8:0] cm;
    logic       e_ill1;
    logic       e_pt1;
    logic [8:0] e_xs;
    logic [8:0] e_os;
    logic [3:0] e_cnt;
    logic       e_wx;
    logic       e_wo;
    logic       e_dr;
    logic       e_ft;
    logic       e_pt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int idx, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s got %0h expected %0h", idx, nm, got, exp);
    end
  endtask

  task automatic add(input logic ng, input logic cf, input logic pv,
                     input logic [8:0] pm, input logic [8:0] cm,
                     input logic ill1, input logic pt1,
                     input logic [8:0] exs, input logic [8:0] eos, input logic [3:0] ecnt,
                     input logic wx, input logic wo, input logic dr, input logic ft,
                     input logic pt);
    vec_t v;
    v.ng = ng; v.cf = cf; v.pv = pv; v.pm = pm; v.cm = cm;
    v.e_ill1 = ill1; v.e_pt1 = pt1;
    v.e_xs = exs; v.e_os = eos; v.e_cnt = ecnt;
    v.e_wx = wx; v.e_wo = wo; v.e_dr = dr; v.e_ft = ft; v.e_pt = pt;
    vecs.push_back(v);
  endtask

  task automatic chk_zero(input int idx);
    chk("xs",          idx, xs, 9'h000);
    chk("os",          idx, os, 9'h000);
    chk("move_count",  idx, 9'(move_count), 9'd0);
    chk("win_x",       idx, 9'(win_x), 9'd0);
    chk("win_o",       idx, 9'(win_o), 9'd0);
    chk("draw",        idx, 9'(draw), 9'd0);
    chk("illegal",     idx, 9'(illegal), 9'd0);
    chk("comp_fault",  idx, 9'(comp_fault), 9'd0);
    chk("player_turn", idx, 9'(player_turn), 9'd0);
  endtask

  initial begin
    vec_t exp_v;
    logic got_ill1;
    logic got_pt1;

    reset_n = 1'b0; new_game = 1'b0; comp_first = 1'b0;
    player_valid = 1'b0; player_move = '0; comp_move = '0;

    //  ng cf pv  pm      cm       ill pt1  xs      os      cnt wx wo dr ft pt
    add(1, 0, 0, 9'h000, 9'h000,  0, 1,  9'h000, 9'h000, 0,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h010, 9'h002,  0, 0,  9'h010, 9'h002, 2,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h002, 9'h000,  1, 1,  9'h010, 9'h002, 2,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h003, 9'h000,  1, 1,  9'h010, 9'h002, 2,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h100, 9'h008,  0, 0,  9'h110, 9'h00A, 4,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h001, 9'h020,  0, 0,  9'h111, 9'h00A, 5,  1, 0, 0, 0, 0);
    add(0, 0, 1, 9'h040, 9'h020,  0, 0,  9'h111, 9'h00A, 5,  1, 0, 0, 0, 0);
    add(1, 0, 1, 9'h010, 9'h000,  0, 1,  9'h000, 9'h000, 0,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h001, 9'h002,  0, 0,  9'h001, 9'h002, 2,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h004, 9'h010,  0, 0,  9'h005, 9'h012, 4,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h008, 9'h020,  0, 0,  9'h00D, 9'h032, 6,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h080, 9'h040,  0, 0,  9'h08D, 9'h072, 8,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h100, 9'h000,  0, 0,  9'h18D, 9'h072, 9,  0, 0, 1, 0, 0);
    add(1, 0, 0, 9'h000, 9'h000,  0, 1,  9'h000, 9'h000, 0,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h010, 9'h000,  0, 0,  9'h010, 9'h000, 1,  0, 0, 0, 1, 0);
    add(1, 0, 0, 9'h000, 9'h000,  0, 1,  9'h000, 9'h000, 0,  0, 0, 0, 0, 1);
    add(1, 1, 0, 9'h000, 9'h011,  0, 0,  9'h000, 9'h000, 0,  0, 0, 0, 1, 0);
    add(1, 1, 0, 9'h000, 9'h010,  0, 0,  9'h000, 9'h010, 1,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h010, 9'h010,  1, 1,  9'h000, 9'h010, 1,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h001, 9'h001,  0, 0,  9'h001, 9'h010, 2,  0, 0, 0, 1, 0);
    add(1, 1, 0, 9'h000, 9'h001,  0, 0,  9'h000, 9'h001, 1,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h010, 9'h002,  0, 0,  9'h010, 9'h003, 3,  0, 0, 0, 0, 1);
    add(0, 0, 1, 9'h100, 9'h004,  0, 0,  9'h110, 9'h007, 5,  0, 1, 0, 0, 0);

    #3;
    chk_zero(-1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk_zero(-1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      new_game     = vecs[i].ng;
      comp_first   = vecs[i].cf;
      player_valid = vecs[i].pv;
      player_move  = vecs[i].pm;
      comp_move    = vecs[i].cm;
      sb_q.push_back(vecs[i]);
      @(negedge clock);
      new_game = 1'b0; comp_first = 1'b0; player_valid = 1'b0;
      got_ill1 = illegal;
      got_pt1  = player_turn;
      repeat (2) @(negedge clock);
      exp_v = sb_q.pop_front();
      chk("illegal_pulse",  i, 9'(got_ill1), 9'(exp_v.e_ill1));
      chk("player_turn_c1", i, 9'(got_pt1), 9'(exp_v.e_pt1));
      chk("xs",             i, xs, exp_v.e_xs);
      chk("os",             i, os, exp_v.e_os);
      chk("move_count",     i, 9'(move_count), 9'(exp_v.e_cnt));
      chk("win_x",          i, 9'(win_x), 9'(exp_v.e_wx));
      chk("win_o",          i, 9'(win_o), 9'(exp_v.e_wo));
      chk("draw",           i, 9'(draw), 9'(exp_v.e_dr));
      chk("comp_fault",     i, 9'(comp_fault), 9'(exp_v.e_ft));
      chk("player_turn",    i, 9'(player_turn), 9'(exp_v.e_pt));
      chk("illegal_late",   i, 9'(illegal), 9'd0);
    end

    // Asynchronous reset in the middle of the computer's turn
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0; player_valid = 1'b1; player_move = 9'h010; comp_move = 9'h001;
    @(negedge clock);
    player_valid = 1'b0;
    chk("mid_xs", 100, xs, 9'h010);
    #2 reset_n = 1'b0;
    #1 chk_zero(100);
    @(negedge clock);
    reset_n = 1'b1;
    // IDLE ignores player requests
    player_valid = 1'b1; player_move = 9'h001;
    @(negedge clock);
    player_valid = 1'b0;
    @(negedge clock);
    chk_zero(101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ttt_board_ctrl.md
# ttt_board_ctrl

Game controller that sits downstream of the four-way move selector. It owns the registered tic-tac-toe board, alternates turns between the human player (X) and the computer (O), and commits the selector's one-hot move to the board. After each move it checks for a win or a draw. The board outputs feed back to the upstream candidate-generation logic, which closes the loop with the selector's one-hot output `comp_move`.

## Interface
Parameters: none (board geometry fixed at 3x3).
- `clock` in 1: single clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `new_game` in 1: clears the board and starts a game; sampled every cycle.
- `comp_first` in 1: sampled only when `new_game`=1; 1 means O moves first.
- `player_valid` in 1: a player move is presented this cycle.
- `player_move` in 9: player's cell request; must be one-hot.
- `comp_move` in 9: one-hot move from the selector, combinational from `xs`/`os`.
- `xs` out 9: X-occupied cells. Bit k is cell k, row-major; bit 0 is top-left and bit 4 is centre.
- `os` out 9: O-occupied cells.
- `player_turn` out 1: high while waiting for the player.
- `win_x`, `win_o`, `draw` out 1 each: final result; held until `new_game` or reset.
- `illegal` out 1: one-cycle pulse when a player move is rejected.
- `comp_fault` out 1: sticky; set when the selector supplies an unusable move.
- `move_count` out 4: number of cells occupied, 0..9.

## Operation
- States:
  - IDLE: after reset.
  - P_WAIT: waiting for the player.
  - C_EVAL: X has just moved or the computer opens; decide the next step.
  - O_CHECK: O has just moved.
  - DONE: game over.
- `new_game` has highest priority in every state. It clears `xs`, `os`, `move_count`, results and `comp_fault`. Next state is C_EVAL if `comp_first`=1, else P_WAIT.
- P_WAIT with `player_valid`=1:
  - Legal move: `player_move` is one-hot and `player_move & (xs|os)`==0. Then `xs |= player_move`, `move_count`+1, next state C_EVAL.
  - Otherwise: pulse `illegal`, leave the board unchanged, stay in P_WAIT.
- C_EVAL, checks in this order:
  - X holds any win line: `win_x`=1, next state DONE.
  - `move_count`==9: `draw`=1, next state DONE.
  - `comp_move` is one-hot and targets an empty cell: `os |= comp_move`, `move_count`+1, next state O_CHECK.
  - Otherwise: `comp_fault`=1, next state DONE with no result flag.
- O_CHECK:
  - O holds a win line: `win_o`=1, next state DONE.
  - `move_count`==9: `draw`=1, next state DONE.
  - Otherwise: next state P_WAIT.
- IDLE and DONE ignore `player_valid`; `illegal` never pulses in these states.
- Win detection: a line L is held when `(board & L)==L`. The line masks are 0x007, 0x038, 0x1C0, 0x049, 0x092, 0x124, 0x111 and 0x054.
- One-hot check: the value is nonzero and `v & (v-1)`==0.

## Timing
- Reset (asynchronous, active-low): `xs`=`os`=0, `move_count`=0, all flags 0, `player_turn`=0, state IDLE.
- `player_turn` = (state==P_WAIT), registered.
- Legal player move accepted at edge N: `xs` updates at edge N.
- `comp_move` is evaluated on the new board during cycle N+1; `os` updates at edge N+1.
- O_CHECK decision is made during cycle N+2; `player_turn` reasserts after edge N+2.
- Total turnaround: three cycles.
- `illegal` is high only during the cycle after the rejected request.
- `player_valid` coinciding with `new_game`: `new_game` wins and the move is dropped.
- Reset asserted mid-game: immediate return to reset values.

## Structure
- Package `ttt_pkg`:
  - `board_t` (logic [8:0]).
  - `WIN_LINES` constant array of 8 line masks.
  - `state_t` enum.
  - Functions `is_onehot` and `has_line`.
- One sub-module, `ttt_line_detect`: combinational board-to-won check, instantiated twice (once for X, once for O).

## Test plan
1. Reset, then `new_game` with `comp_first`=0 → IDLE→P_WAIT; `xs`=`os`=0; `player_turn`=1 one cycle later.
2. Player plays 0x010 while the bench drives `comp_move`=0x001 → `xs`=0x010, then `os`=0x001, `move_count`=2, `player_turn` back three cycles after the move.
3. Player plays 0x001 onto an O-occupied cell, then 0x003 (not one-hot) → `illegal` pulses twice; board and `move_count` unchanged.
4. X completes 0x111 → `win_x`=1 in C_EVAL, the `comp_move` value is ignored, `os` unchanged, state DONE; later `player_valid` has no effect.
5. Full-board game with no line, ending on the player's 9th-cell move → `draw`=1, `move_count`=9.
6. `comp_move`=0x000, and separately `comp_move`=0x011 → `comp_fault`=1, state DONE; a following `new_game` clears it.
